simple_uart_rx_framer: RTL and testbench



---
 rtl/simple_uart_frame_pkg.sv | 19 +
 rtl/simple_uart_frame_buf.sv | 27 ++
 rtl/simple_uart_rx_framer.sv | 183 ++++++++++++++++++
 tb/tb_simple_uart_rx_framer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_frame_pkg.sv
// Shared types and helpers for the UART frame decoder.
// State encoding, default sync byte and LEN counter width function.
package simple_uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/simple_uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write
// port (i_we/i_waddr/i_wdata), one combinational read port (i_raddr/o_rdata).
module simple_uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    // Rounded up to a power of two so every address is in range.
    logic [7:0] r_mem [2**AW];

    // Contents are never cleared; only the framer's idx/len matter.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simple_uart_rx_framer.sv
// Sync/length/checksum frame decoder behind a UART receiver.
// In: rx_value/rx_value_ready, m_ready. Out: m_data/m_valid/m_last + pulses.
module simple_uart_rx_framer
    import simple_uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       arst_n,
    input  logic [7:0] rx_value,
    input  logic       rx_value_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       len_err,
    output logic       chk_err,
    output logic       timeout_err,
    output logic       overrun_err
);

    localparam int LW = len_width(MAX_LEN);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_m_data;
    logic          r_m_valid;
    logic          r_m_last;
    logic          r_frame_ok;
    logic          r_len_err;
    logic          r_chk_err;
    logic          r_timeout_err;
    logic          r_overrun_err;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic [7:0]    w_rdata;
    logic [7:0]    w_sum_next;
    logic          w_tmo_hit;
    logic          w_in_frame;
    logic          w_hs;

    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD)
                     || (r_state == ST_CHECK);
    // A byte arriving in the terminal cycle wins over the timeout.
    assign w_tmo_hit  = w_in_frame && !rx_value_ready
                     && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_sum_next = r_sum + rx_value;
    assign w_hs       = r_m_valid && m_ready;
    assign w_we       = (r_state == ST_PAYLOAD) && rx_value_ready;
    assign w_waddr    = AW'(r_idx);
    // Look one entry ahead: m_data is loaded with the next byte on each
    // handshake, and with entry 0 when the checksum byte is accepted.
    assign w_raddr    = (r_state == ST_DRAIN) ? AW'(r_idx) + AW'(1) : '0;

    simple_uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (rx_value),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= ST_HUNT;
            r_len         <= '0;
            r_idx         <= '0;
            r_sum         <= '0;
            r_tmo         <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_len_err     <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_ok    <= 1'b0;
            r_len_err     <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;

            if (w_in_frame && !rx_value_ready) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end

            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
                r_state       <= ST_HUNT;
                r_tmo         <= '0;
            end else begin
                unique case (r_state)
                    ST_HUNT: begin
                        if (rx_value_ready && rx_value == SYNC_BYTE) begin
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_value_ready) begin
                            if (rx_value == 8'd0 || int'(rx_value) > MAX_LEN) begin
                                r_len_err <= 1'b1;
                                r_state   <= ST_HUNT;
                            end else begin
                                r_len   <= LW'(rx_value);
                                r_sum   <= rx_value;
                                r_idx   <= '0;
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_value_ready) begin
                            r_sum <= w_sum_next;
                            r_idx <= r_idx + LW'(1);
                            if (r_idx == r_len - LW'(1)) begin
                                r_state <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (rx_value_ready) begin
                            if (w_sum_next == 8'd0) begin
                                r_frame_ok <= 1'b1;
                                r_idx      <= '0;
                                r_m_valid  <= 1'b1;
                                r_m_data   <= w_rdata;
                                r_m_last   <= (r_len == LW'(1));
                                r_state    <= ST_DRAIN;
                            end else begin
                                r_chk_err <= 1'b1;
                                r_state   <= ST_HUNT;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Nothing is parsed while draining.
                        r_overrun_err <= rx_value_ready;
                        if (w_hs) begin
                            if (r_m_last) begin
                                r_m_valid <= 1'b0;
                                r_m_last  <= 1'b0;
                                r_state   <= ST_HUNT;
                            end else begin
                                r_idx    <= r_idx + LW'(1);
                                r_m_data <= w_rdata;
                                r_m_last <= (r_idx + LW'(2) == r_len);
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign frame_ok    = r_frame_ok;
    assign len_err     = r_len_err;
    assign chk_err     = r_chk_err;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_simple_uart_rx_framer.sv
// Directed bench for simple_uart_rx_framer.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_simple_uart_rx_framer;

    localparam int ML = 16;
    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] rx_value = 8'h00;
    logic       rx_value_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_last;
    logic       frame_ok;
    logic       len_err;
    logic       chk_err;
    logic       timeout_err;
    logic       overrun_err;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    always #5 clock = ~clock;

    simple_uart_rx_framer #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (ML),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .arst_n         (arst_n),
        .rx_value       (rx_value),
        .rx_value_ready (rx_value_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .frame_ok       (frame_ok),
        .len_err        (len_err),
        .chk_err        (chk_err),
        .timeout_err    (timeout_err),
        .overrun_err    (overrun_err)
    );

    always @(posedge clock) begin
        if (m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; byte is taken on the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_value = b;
        rx_value_ready = 1'b1;
        @(negedge clock);
        rx_value_ready = 1'b0;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        int h0;
        int tmo_seen;
        int tmo_at;

        repeat (2) tick();
        check("rst_valid", 16'(m_valid), 16'd0);
        check("rst_last", 16'(m_last), 16'd0);
        check("rst_data", 16'(m_data), 16'h00);
        check("rst_ok", 16'(frame_ok), 16'd0);
        check("rst_errs", 16'({len_err, chk_err, timeout_err, overrun_err}), 16'd0);
        arst_n = 1'b1;
        tick();

        // Good frame, sink always ready. 03+11+22+33 = 69, CHK = 97.
        m_ready = 1'b1;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h97);
        check("g_ok", 16'(frame_ok), 16'd1);
        check("g_v0", 16'(m_valid), 16'd1);
        check("g_d0", 16'(m_data), 16'h11);
        check("g_l0", 16'(m_last), 16'd0);
        tick();
        check("g_ok_pulse", 16'(frame_ok), 16'd0);
        check("g_d1", 16'(m_data), 16'h22);
        check("g_l1", 16'(m_last), 16'd0);
        tick();
        check("g_d2", 16'(m_data), 16'h33);
        check("g_l2", 16'(m_last), 16'd1);
        check("g_v2", 16'(m_valid), 16'd1);
        tick();
        check("g_vend", 16'(m_valid), 16'd0);

        // Backpressure: ready 1-0-0-1 after first byte shows.
        m_ready = 1'b0;
        h0 = hs_cnt;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h97);
        check("bp_d0", 16'(m_data), 16'h11);
        tick();
        check("bp_d0_hold", 16'(m_data), 16'h11);
        m_ready = 1'b1;
        tick();
        check("bp_d1", 16'(m_data), 16'h22);
        m_ready = 1'b0;
        tick();
        check("bp_d1_hold", 16'(m_data), 16'h22);
        check("bp_l1_hold", 16'(m_last), 16'd0);
        tick();
        check("bp_d1_hold2", 16'(m_data), 16'h22);
        check("bp_v_hold", 16'(m_valid), 16'd1);
        m_ready = 1'b1;
        tick();
        check("bp_d2", 16'(m_data), 16'h33);
        check("bp_l2", 16'(m_last), 16'd1);
        tick();
        check("bp_vend", 16'(m_valid), 16'd0);
        check("bp_hs", 16'(hs_cnt - h0), 16'd3);

        // Bad checksum then a good one-byte frame.
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
        check("cb_err", 16'(chk_err), 16'd1);
        check("cb_valid", 16'(m_valid), 16'd0);
        tick();
        check("cb_pulse", 16'(chk_err), 16'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        check("c1_ok", 16'(frame_ok), 16'd1);
        check("c1_d", 16'(m_data), 16'h7F);
        check("c1_l", 16'(m_last), 16'd1);
        tick();
        check("c1_vend", 16'(m_valid), 16'd0);

        // Junk ignored; zero and oversize lengths rejected.
        send(8'h00);
        check("junk0", 16'({len_err, chk_err, timeout_err}), 16'd0);
        send(8'hFF);
        check("junk1", 16'({len_err, chk_err, timeout_err}), 16'd0);
        send(8'hA5); send(8'h00);
        check("len0", 16'(len_err), 16'd1);
        send(8'hA5); send(8'(ML + 1));
        check("len_big", 16'(len_err), 16'd1);
        tick();
        check("len_pulse", 16'(len_err), 16'd0);

        // Timeout: silence after byte 01.
        send(8'hA5); send(8'h02); send(8'h01);
        tmo_seen = 0;
        tmo_at = 0;
        for (int k = 1; k <= TO + 2; k++) begin
            tick();
            if (timeout_err) begin
                tmo_seen++;
                if (tmo_at == 0) tmo_at = k;
            end
        end
        check("tmo_at", 16'(tmo_at), 16'(TO));
        check("tmo_once", 16'(tmo_seen), 16'd1);

        // Byte in the terminal cycle keeps the frame alive.
        send(8'hA5); send(8'h02); send(8'h01);
        repeat (TO - 1) tick();
        send(8'h02);
        check("tmo_sup", 16'(timeout_err), 16'd0);
        send(8'hFB);
        check("tmo_sup_ok", 16'(frame_ok), 16'd1);
        check("tmo_sup_d0", 16'(m_data), 16'h01);
        tick();
        check("tmo_sup_d1", 16'(m_data), 16'h02);
        tick();

        // Overrun during a stalled drain. 04+01+02+03+04 = 0E, CHK = F2.
        m_ready = 1'b0;
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03);
        send(8'h04); send(8'hF2);
        check("ov_d0", 16'(m_data), 16'h01);
        send(8'hA5);
        check("ov_err", 16'(overrun_err), 16'd1);
        check("ov_d0_keep", 16'(m_data), 16'h01);
        m_ready = 1'b1;
        tick();
        check("ov_pulse", 16'(overrun_err), 16'd0);
        check("ov_d1", 16'(m_data), 16'h02);
        tick();
        check("ov_d2", 16'(m_data), 16'h03);
        tick();
        check("ov_d3", 16'(m_data), 16'h04);
        check("ov_l3", 16'(m_last), 16'd1);
        tick();
        check("ov_vend", 16'(m_valid), 16'd0);
        // Had the dropped A5 been taken as SYNC this would frame.
        send(8'h01); send(8'h7F); send(8'h80);
        check("ov_nosync", 16'({frame_ok, m_valid}), 16'd0);

        // Reset mid-drain.
        m_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        check("rd_pre", 16'(m_valid), 16'd1);
        #1 arst_n = 1'b0;
        #1;
        check("rd_valid", 16'(m_valid), 16'd0);
        check("rd_data", 16'(m_data), 16'h00);
        check("rd_last", 16'(m_last), 16'd0);
        tick();
        arst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        check("rd_idle", 16'(m_valid), 16'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        check("rd_after", 16'({frame_ok, m_valid, m_last}), 16'h7);
        check("rd_after_d", 16'(m_data), 16'h7F);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
